// File: rtl/mul_sequencer_pkg.sv
// Shared constants for the shift-and-add multiplier sequencer.
// State codes and the default operand width.
package mul_sequencer_pkg;

  localparam int MUL_L = 16;

  localparam logic [2:0] MUL_IDLE = 3'd0;
  localparam logic [2:0] MUL_PREP = 3'd1;
  localparam logic [2:0] MUL_RUN  = 3'd2;
  localparam logic [2:0] MUL_FIX  = 3'd3;
  localparam logic [2:0] MUL_DONE = 3'd4;

endpackage

// File: rtl/mul_sequencer_fa.sv
// Ripple full adder shared by the multiplier iterations.
// The carry out of the top bit position is exported as o_cout.
module mul_sequencer_fa #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
  assign o_sum  = w_full[W-1:0];
  assign o_cout = w_full[W];

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-and-add multiplier with valid/ready on both sides.
// Signed operands are multiplied as magnitudes and negated at the end.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int l = MUL_L
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start_valid,
  output logic           o_start_ready,
  input  logic [l-1:0]   i_a,
  input  logic [l-1:0]   i_b,
  input  logic           i_is_signed,
  output logic           o_busy,
  output logic           o_res_valid,
  input  logic           i_res_ready,
  output logic [2*l-1:0] o_product,
  output logic           o_overflow
);

  localparam int CW = $clog2(l);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(l - 1);
  localparam logic [l-1:0]   ONE_L    = l'(1);
  localparam logic [2*l-1:0] ONE_2L   = (2*l)'(1);

  logic [2:0]     r_state;
  logic [2:0]     w_next;
  logic [l-1:0]   r_a;
  logic [l-1:0]   r_b;
  logic           r_sgn;
  logic [l-1:0]   r_mcand;
  logic [l-1:0]   r_mq;
  // The accumulator's extra top bit is always zero after the
  // right shift, so only the low l bits are kept.
  logic [l-1:0]   r_acc;
  logic           r_neg;
  logic [CW-1:0]  r_cnt;
  logic [2*l-1:0] r_prod;
  logic           r_ovf;

  logic           w_accept;
  logic [l-1:0]   w_abs_a;
  logic [l-1:0]   w_abs_b;
  logic [l-1:0]   w_addend;
  logic [l-1:0]   w_sum;
  logic           w_cout;
  logic [2*l-1:0] w_p;
  logic [2*l-1:0] w_pf;
  logic           w_ovf;

  assign w_accept = i_start_valid && (r_state == MUL_IDLE);

  assign w_abs_a = (r_sgn && r_a[l-1]) ? (~r_a + ONE_L) : r_a;
  assign w_abs_b = (r_sgn && r_b[l-1]) ? (~r_b + ONE_L) : r_b;

  assign w_addend = r_mq[0] ? r_mcand : '0;

  mul_sequencer_fa #(
    .W(l)
  ) u_fa (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .i_cin (1'b0),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  assign w_p  = {r_acc, r_mq};
  assign w_pf = r_neg ? (~w_p + ONE_2L) : w_p;
  assign w_ovf = r_sgn ? (w_pf[2*l-1:l] != {l{w_pf[l-1]}})
                       : (|w_pf[2*l-1:l]);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= MUL_IDLE;
    else       r_state <= w_next;
  end

  // Next-state sequencing through the five phases.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MUL_IDLE: if (w_accept) w_next = MUL_PREP;
      MUL_PREP: w_next = MUL_RUN;
      MUL_RUN:  if (r_cnt == CNT_LAST) w_next = MUL_FIX;
      MUL_FIX:  w_next = MUL_DONE;
      MUL_DONE: if (i_res_ready) w_next = MUL_IDLE;
      default:  w_next = MUL_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    o_start_ready = (r_state == MUL_IDLE);
    o_busy        = (r_state != MUL_IDLE);
    o_res_valid   = (r_state == MUL_DONE);
  end

  assign o_product  = r_prod;
  assign o_overflow = r_ovf;

  // Datapath: latch, convert, iterate, then fix sign and overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_mcand <= '0;
      r_mq    <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        MUL_IDLE: begin
          if (w_accept) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_sgn <= i_is_signed;
          end
        end
        MUL_PREP: begin
          r_mcand <= w_abs_a;
          r_mq    <= w_abs_b;
          r_neg   <= r_sgn && (r_a[l-1] ^ r_b[l-1]);
          r_acc   <= '0;
          r_cnt   <= '0;
        end
        MUL_RUN: begin
          r_acc <= {w_cout, w_sum[l-1:1]};
          r_mq  <= {w_sum[0], r_mq[l-1:1]};
          r_cnt <= r_cnt + CNT_ONE;
        end
        MUL_FIX: begin
          r_prod <= w_pf;
          r_ovf  <= w_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed table,
// backpressure, mid-run reset and randomized operations.
module tb_mul_sequencer;

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        is_signed;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] product;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  mul_sequencer #(.l(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start_valid(start_valid),
    .o_start_ready(start_ready),
    .i_a          (a),
    .i_b          (b),
    .i_is_signed  (is_signed),
    .o_busy       (busy),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_product    (product),
    .o_overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          s;
    logic [31:0] p;
    bit          o;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout", nm);
  endtask

  function automatic void ref_mul(input logic [15:0] x,
                                  input logic [15:0] y,
                                  input bit s,
                                  output logic [31:0] p,
                                  output bit o);
    longint vx, vy, r;
    vx = s ? longint'($signed(x)) : longint'({48'b0, x});
    vy = s ? longint'($signed(y)) : longint'({48'b0, y});
    r  = vx * vy;
    p  = r[31:0];
    o  = s ? (r < -32768 || r > 32767) : (r > 65535);
  endfunction

  task automatic issue(input logic [15:0] x, input logic [15:0] y,
                       input bit s);
    a = x;
    b = y;
    is_signed = s;
    start_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (start_ready) break;
      @(posedge clk);
      #1;
    end
    if (!start_ready) timeout("start_ready");
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!res_valid) timeout("res_valid");
  endtask

  task automatic retire();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        input bit s, input int hold,
                        output logic [31:0] p, output bit o,
                        output int lat);
    issue(x, y, s);
    wait_valid(lat);
    p = product;
    o = overflow;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    retire();
  endtask

  vec_t        tbl[5];
  logic [31:0] gp, ep;
  bit          go, eo;
  int          lat;
  logic [15:0] ra, rb;
  bit          rs;
  logic [15:0] corner[5];

  initial begin
    rst = 1'b1;
    start_valid = 1'b0;
    a = '0;
    b = '0;
    is_signed = 1'b0;
    res_ready = 1'b0;

    tbl[0] = '{16'h0003, 16'h0005, 1'b0, 32'h0000000F, 1'b0};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b1};
    tbl[2] = '{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 1'b0};
    tbl[3] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b1};
    tbl[4] = '{16'h0000, 16'h8000, 1'b1, 32'h00000000, 1'b0};

    corner[0] = 16'h0000;
    corner[1] = 16'h8000;
    corner[2] = 16'hFFFF;
    corner[3] = 16'h7FFF;
    corner[4] = 16'h0001;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst start_ready", 32'(start_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst product", product, 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, 0, gp, go, lat);
      chk($sformatf("tbl%0d product", i), gp, tbl[i].p);
      chk($sformatf("tbl%0d overflow", i), 32'(go), 32'(tbl[i].o));
      chk($sformatf("tbl%0d latency", i), 32'(lat), 32'd18);
    end

    issue(16'd7, 16'd9, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      chk("bp product", product, 32'd63);
      chk("bp start_ready", 32'(start_ready), 32'd0);
      chk("bp res_valid", 32'(res_valid), 32'd1);
      if (i == 3) begin
        a = 16'd5;
        b = 16'd5;
        start_valid = 1'b1;
      end
      if (i == 4) start_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    retire();
    chk("bp idle res_valid", 32'(res_valid), 32'd0);
    chk("bp idle start_ready", 32'(start_ready), 32'd1);
    chk("bp idle busy", 32'(busy), 32'd0);
    chk("bp idle product", product, 32'd63);
    @(posedge clk);
    #1;
    chk("bp no accept busy", 32'(busy), 32'd0);

    issue(16'd1234, 16'd567, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    chk("mid busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst res_valid", 32'(res_valid), 32'd0);
    chk("mid rst product", product, 32'd0);
    chk("mid rst overflow", 32'(overflow), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid rel start_ready", 32'(start_ready), 32'd1);
    run_op(16'd2, 16'd2, 1'b0, 0, gp, go, lat);
    chk("after rst product", gp, 32'd4);
    chk("after rst overflow", 32'(go), 32'd0);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)]
                                       : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)]
                                       : 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      ref_mul(ra, rb, rs, ep, eo);
      run_op(ra, rb, rs, $urandom_range(0, 3), gp, go, lat);
      chk($sformatf("rnd%0d %h*%h s%0d prod", i, ra, rb, rs), gp, ep);
      chk($sformatf("rnd%0d ovf", i), 32'(go), 32'(eo));
      chk($sformatf("rnd%0d latency", i), 32'(lat), 32'd18);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
